// File: rtl/booth_mul_pkg.sv
// Shared types for the iterative radix-4 Booth multiplier: FSM states,
// partial-product selections, signedness modes and the group decoder.
package booth_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_sel_e;

    // bit0 = multiplicand signed, bit1 = multiplier signed
    localparam logic [1:0] MODE_UU = 2'b00;
    localparam logic [1:0] MODE_SU = 2'b01;
    localparam logic [1:0] MODE_US = 2'b10;
    localparam logic [1:0] MODE_SS = 2'b11;

    // Group is {b[2i+1], b[2i], b[2i-1]}; value = -2*g[2] + g[1] + g[0].
    function automatic booth_sel_e booth_decode(input logic [2:0] grp);
        booth_sel_e sel;
        case (grp)
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational radix-4 Booth partial-product generator: decodes one 3-bit
// group and returns the selected multiple of the multiplicand, sign-extended.
module booth_pp_gen
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH+1:0]   i_mcand,
    input  logic [2:0]         i_group,
    output logic [2*WIDTH+3:0] o_pp
);

    // One extra bit over the extended multiplicand so that +/-2A never overflows.
    localparam int PW = WIDTH + 3;

    booth_sel_e      w_sel;
    logic [PW-1:0]   w_a1;
    logic [PW-1:0]   w_a2;
    logic [PW-1:0]   w_mag;

    assign w_sel = booth_decode(i_group);
    assign w_a1  = {i_mcand[WIDTH+1], i_mcand};
    assign w_a2  = {i_mcand, 1'b0};

    always_comb begin
        w_mag = '0;
        case (w_sel)
            POS1:    w_mag = w_a1;
            POS2:    w_mag = w_a2;
            NEG1:    w_mag = ~w_a1 + PW'(1);
            NEG2:    w_mag = ~w_a2 + PW'(1);
            default: w_mag = '0;
        endcase
    end

    assign o_pp = {{(WIDTH+1){w_mag[PW-1]}}, w_mag};

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier: one Booth group per cycle, valid/ready
// handshakes on both sides, flush abort and asynchronous active-low reset.
module booth_mul_iter
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int ITER  = (WIDTH + 2) / 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   mul_a,
    input  logic [WIDTH-1:0]   mul_b,
    input  logic [1:0]         mul_signed,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(ITER + 1);
    localparam int ACC_W = 2 * WIDTH + 4;
    localparam int MLT_W = WIDTH + 3;

    state_e             r_state;
    state_e             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [WIDTH+1:0]   r_mcand;
    logic [MLT_W-1:0]   r_mult;

    logic               w_fire;
    logic               w_last;
    logic               w_a_sgn;
    logic               w_b_sgn;
    logic [WIDTH+1:0]   w_a_ext;
    logic [MLT_W-1:0]   w_b_ext;
    logic [ACC_W-1:0]   w_pp;
    logic [ACC_W-1:0]   w_pp_sh;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign product   = r_acc[2*WIDTH-1:0];

    assign w_fire = in_valid && in_ready && !flush;
    assign w_last = (r_cnt == CNT_W'(ITER - 1));

    assign w_a_sgn = (mul_signed == MODE_SU) || (mul_signed == MODE_SS);
    assign w_b_sgn = (mul_signed == MODE_US) || (mul_signed == MODE_SS);
    assign w_a_ext = {{2{w_a_sgn & mul_a[WIDTH-1]}}, mul_a};
    assign w_b_ext = {{2{w_b_sgn & mul_b[WIDTH-1]}}, mul_b, 1'b0};

    // The multiplier register shifts right by two each step, so the current
    // group always sits in its low three bits.
    booth_pp_gen #(
        .WIDTH (WIDTH)
    ) u_pp_gen (
        .i_mcand (r_mcand),
        .i_group (r_mult[2:0]),
        .o_pp    (w_pp)
    );

    assign w_pp_sh = w_pp << {r_cnt, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (in_valid)  w_state_next = BUSY;
                BUSY:    if (w_last)    w_state_next = DONE;
                DONE:    if (out_ready) w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_mult  <= '0;
        end else if (flush) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_fire) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= w_a_ext;
            r_mult  <= w_b_ext;
        end else if (r_state == BUSY) begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_acc  <= r_acc + w_pp_sh;
            r_mult <= r_mult >> 2;
        end
    end

endmodule

// File: tb/tb_booth_mul_iter.sv
// Self-checking bench for booth_mul_iter (WIDTH=64): directed vectors,
// back-pressure, flush, reset abort and a randomized mode-mixed run.
module tb_booth_mul_iter;

    localparam int W   = 64;
    localparam int LAT = (W + 2) / 2 + 1;
    localparam int NRAND = 1200;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   mul_a = '0;
    logic [W-1:0]   mul_b = '0;
    logic [1:0]     mul_signed = 2'b00;
    logic           flush = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] product;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_mul_iter #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_signed (mul_signed),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .product    (product)
    );

    // Exact product of the interpreted operands, reduced mod 2^(2W).
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [1:0] m);
        logic [2*W+1:0] ea;
        logic [2*W+1:0] eb;
        logic [2*W+1:0] p;
        ea = {{(W+2){m[0] & a[W-1]}}, a};
        eb = {{(W+2){m[1] & b[W-1]}}, b};
        p  = ea * eb;
        return p[2*W-1:0];
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            4:       v = W'(1);
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Presents one operation from IDLE and waits (bounded) for out_valid.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m,
                         input bit noise, output logic [2*W-1:0] p, output int lat,
                         output bit rdy_leak);
        @(negedge clk);
        mul_a = a; mul_b = b; mul_signed = m; in_valid = 1'b1;
        @(negedge clk);
        in_valid = noise;
        mul_a = {$urandom, $urandom};
        mul_b = {$urandom, $urandom};
        mul_signed = 2'($urandom_range(0, 3));
        lat = 1;
        rdy_leak = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_leak = 1'b1;
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) lat = -1;
        if (in_ready) rdy_leak = 1'b1;
        p = product;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        mul_a = 64'd7; mul_b = 64'd9;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b prod=%h expected rdy=1 vld=0 prod=0",
                     in_ready, out_valid, product);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_capture: got rdy=%b vld=%b expected rdy=1 vld=0",
                     in_ready, out_valid);
        end
        $display("reset: rdy=%b vld=%b prod=%h", in_ready, out_valid, product);
    endtask

    task automatic test_vectors();
        logic [W-1:0]   va [5];
        logic [W-1:0]   vb [5];
        logic [1:0]     vm [5];
        logic [2*W-1:0] ve [5];
        logic [2*W-1:0] p;
        int lat;
        bit leak;
        va[0] = '1;             vb[0] = '1;             vm[0] = 2'b11; ve[0] = 128'd1;
        va[1] = '1;             vb[1] = '1;             vm[1] = 2'b00;
        ve[1] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
        va[2] = '1;             vb[2] = '1;             vm[2] = 2'b01;
        ve[2] = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001;
        va[3] = 64'h8000_0000_0000_0000; vb[3] = 64'h8000_0000_0000_0000; vm[3] = 2'b11;
        ve[3] = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
        va[4] = 64'd3;          vb[4] = 64'd5;          vm[4] = 2'b00; ve[4] = 128'd15;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vm[i], 1'b0, p, lat, leak);
            checks++;
            if (p !== ve[i]) begin
                errors++;
                $display("FAIL vec%0d_product: got %h expected %h", i, p, ve[i]);
            end
            checks++;
            if (lat != LAT) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, LAT);
            end
            checks++;
            if (leak) begin
                errors++;
                $display("FAIL vec%0d_in_ready_busy: got in_ready=1 expected 0 while busy", i);
            end
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d_hold: got rdy=%b vld=%b expected rdy=0 vld=1",
                         i, in_ready, out_valid);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_release: got rdy=%b vld=%b expected rdy=1 vld=0",
                         i, in_ready, out_valid);
            end
            $display("vec%0d: a=%h b=%h mode=%b product=%h lat=%0d", i, va[i], vb[i], vm[i], p, lat);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] e;
        logic [2*W-1:0] p;
        int lat;
        bit leak;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        e = ref_mul(a, b, 2'b11);
        do_op(a, b, 2'b11, 1'b0, p, lat, leak);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (product !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got prod=%h vld=%b rdy=%b expected prod=%h vld=1 rdy=0",
                         k, product, out_valid, in_ready, e);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
        $display("backpressure: a=%h b=%h product=%h", a, b, e);
    endtask

    task automatic test_flush();
        logic [2*W-1:0] p;
        int lat;
        bit leak;
        bit seen;
        @(negedge clk);
        mul_a = {$urandom, $urandom}; mul_b = {$urandom, $urandom}; mul_signed = 2'b11;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; mul_a = 64'd11; mul_b = 64'd13; mul_signed = 2'b00;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy_before: got rdy=%b expected 0", in_ready);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_no_result: got activity=1 expected 0 after flush");
        end
        do_op(64'd3, 64'd5, 2'b00, 1'b0, p, lat, leak);
        checks++;
        if (p !== 128'd15) begin
            errors++;
            $display("FAIL flush_next_op: got %h expected %h", p, 128'd15);
        end
        // Flush in DONE beats a simultaneous out_ready and drops out_valid.
        out_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        // Flush in IDLE beats in_valid: nothing is captured.
        in_valid = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: got vld=%b rdy=%b expected vld=0 rdy=1", out_valid, in_ready);
        end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle_priority: got rdy=%b expected 1", in_ready);
        end
        $display("flush: next op 3*5 product=%h", p);
    endtask

    task automatic test_rst_abort();
        logic [2*W-1:0] p;
        int lat;
        bit leak;
        bit seen;
        @(negedge clk);
        mul_a = {$urandom, $urandom}; mul_b = {$urandom, $urandom}; mul_signed = 2'b10;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (18) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
            errors++;
            $display("FAIL rst_busy_async: got rdy=%b vld=%b prod=%h expected rdy=1 vld=0 prod=0",
                     in_ready, out_valid, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_busy_no_result: got out_valid=1 expected 0 after reset abort");
        end
        do_op({$urandom, $urandom}, {$urandom, $urandom}, 2'b01, 1'b0, p, lat, leak);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_done_async: got vld=%b rdy=%b expected vld=0 rdy=1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_done_no_result: got vld=%b expected 0", out_valid);
        end
        $display("rst_abort: reset during busy and done dropped the operation");
    endtask

    task automatic test_random();
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [1:0]     m;
        logic [2*W-1:0] e;
        logic [2*W-1:0] p;
        int lat;
        bit leak;
        bit noise;
        int bp;
        for (int i = 0; i < NRAND; i++) begin
            a = pick();
            b = pick();
            m = 2'($urandom_range(0, 3));
            noise = 1'($urandom_range(0, 1));
            e = ref_mul(a, b, m);
            do_op(a, b, m, noise, p, lat, leak);
            checks++;
            if (lat != LAT || leak) begin
                errors++;
                $display("FAIL rand%0d_timing: got lat=%0d leak=%b expected lat=%0d leak=0",
                         i, lat, leak, LAT);
            end
            bp = $urandom_range(0, 2);
            repeat (bp) @(negedge clk);
            checks++;
            if (product !== e) begin
                errors++;
                $display("FAIL rand%0d_product: got %h expected %h (a=%h b=%h mode=%b)",
                         i, product, e, a, b, m);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            $display("rand%0d: a=%h b=%h mode=%b product=%h", i, a, b, m, p);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_flush();
        test_rst_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
